// File: rtl/uart_baud_gen_pkg.sv
// Shared constants and helpers for the UART baud-rate generator.
// Holds the default clock and baud rates plus the accumulator width rule.
package uart_baud_gen_pkg;

    localparam int DEF_CLOCK_SPEED = 100_000_000;
    localparam int DEF_BAUD_RATE   = 115_200;

    // The extra bit keeps acc + baud_rate from wrapping before the compare.
    function automatic int acc_width(input longint clock_speed, input longint rate);
        return $clog2(clock_speed + rate) + 1;
    endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Baud tick bundle between the generator and the UART TX/RX bit engines.
// The master drives the strobe; bit engines listen on the slave side.
interface uart_baud_gen_if;

    logic baud_ena;

    modport master (output baud_ena);
    modport slave  (input  baud_ena);

endinterface

// File: rtl/uart_baud_gen.sv
// Fractional baud tick: phase accumulator adds baud_rate, wraps at baud_clock_speed.
// Latency: baud_ena registered, 1 cycle after the wrapping edge. Backpressure: none, free-running.
module uart_baud_gen
    import uart_baud_gen_pkg::*;
#(
    parameter int baud_clock_speed = DEF_CLOCK_SPEED,
    parameter int baud_rate        = DEF_BAUD_RATE
) (
    input  logic uart_clk,
    input  logic uart_rst,
    output logic baud_ena
);

    localparam int ACC_W = acc_width(longint'(baud_clock_speed), longint'(baud_rate));

    localparam logic [ACC_W-1:0] INC = ACC_W'(baud_rate);
    localparam logic [ACC_W-1:0] DIV = ACC_W'(baud_clock_speed);

    if (baud_clock_speed <= 0 || baud_rate <= 0 || baud_rate > baud_clock_speed) begin : g_bad_params
        $error("uart_baud_gen: illegal parameters baud_clock_speed=%0d baud_rate=%0d",
               baud_clock_speed, baud_rate);
    end

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] sum;
    logic             ena_q;
    logic             ena_d;

    // A single subtract suffices: acc < C and B <= C keep sum below 2*C.
    always_comb begin
        sum   = acc_q + INC;
        acc_d = sum;
        ena_d = 1'b0;
        if (sum >= DIV) begin
            acc_d = sum - DIV;
            ena_d = 1'b1;
        end
    end

    always_ff @(posedge uart_clk) begin
        if (!uart_rst) begin
            acc_q <= '0;
            ena_q <= 1'b0;
        end else begin
            acc_q <= acc_d;
            ena_q <= ena_d;
        end
    end

    assign baud_ena = ena_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: three parameter sets run side by side against a
// tick-count model (a tick lands on cycle n exactly when floor(n*B/C) steps up).
module tb_uart_baud_gen;

    logic uart_clk = 1'b0;
    always #5 uart_clk = ~uart_clk;

    logic rst0;
    logic rst1;
    logic rst2;

    uart_baud_gen_if bif0 ();
    uart_baud_gen_if bif1 ();
    uart_baud_gen_if bif2 ();

    uart_baud_gen #(.baud_clock_speed(10_000_000), .baud_rate(912_600)) u0 (
        .uart_clk (uart_clk),
        .uart_rst (rst0),
        .baud_ena (bif0.baud_ena)
    );

    uart_baud_gen #(.baud_clock_speed(10_000_000), .baud_rate(1_000_000)) u1 (
        .uart_clk (uart_clk),
        .uart_rst (rst1),
        .baud_ena (bif1.baud_ena)
    );

    uart_baud_gen #(.baud_clock_speed(50_000_000), .baud_rate(50_000_000)) u2 (
        .uart_clk (uart_clk),
        .uart_rst (rst2),
        .baud_ena (bif2.baud_ena)
    );

    logic [2:0] ena_v;
    assign ena_v = {bif2.baud_ena, bif1.baud_ena, bif0.baud_ena};

    int total = 0;
    int bad   = 0;

    longint cs [3] = '{64'd10_000_000, 64'd10_000_000, 64'd50_000_000};
    longint bs [3] = '{64'd912_600,    64'd1_000_000,  64'd50_000_000};

    longint n       [3];
    longint last_n  [3];
    longint first_n [3];
    longint ticks   [3];

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint floor_ticks(input int i, input longint cnt);
        return (cnt * bs[i]) / cs[i];
    endfunction

    // One clock: drive resets at the falling edge, advance the model at the
    // rising edge, then check every instance at the next falling edge.
    task automatic cycle(input logic r0, input logic r1, input logic r2);
        logic [2:0] r;
        longint expv;
        longint gap;
        r    = {r2, r1, r0};
        rst0 = r0;
        rst1 = r1;
        rst2 = r2;
        @(posedge uart_clk);
        for (int i = 0; i < 3; i++) n[i] = r[i] ? n[i] + 1 : 0;
        @(negedge uart_clk);
        for (int i = 0; i < 3; i++) begin
            if (n[i] == 0) expv = 0;
            else expv = (floor_ticks(i, n[i]) != floor_ticks(i, n[i] - 1)) ? 1 : 0;
            chk($sformatf("ena%0d_n%0d", i, n[i]), longint'(ena_v[i]), expv);
            if (n[i] == 0) begin
                ticks[i]   = 0;
                last_n[i]  = 0;
                first_n[i] = 0;
            end else if (ena_v[i] === 1'b1) begin
                ticks[i]++;
                gap = n[i] - last_n[i];
                if (first_n[i] == 0) first_n[i] = n[i];
                else if (i == 0) chk("gap0_10_or_11", (gap == 10 || gap == 11) ? 1 : 0, 1);
                else if (i == 1) chk("gap1", gap, 10);
                last_n[i] = n[i];
            end
            if (n[i] != 0 && n[i] % 97 == 0)
                chk($sformatf("ticks%0d_at_n%0d", i, n[i]), ticks[i], floor_ticks(i, n[i]));
        end
    endtask

    initial begin
        int     k;
        int     len;
        logic   found;
        logic   r0;
        logic   r1;
        logic   r2;

        for (int i = 0; i < 3; i++) begin
            n[i]       = 0;
            last_n[i]  = 0;
            first_n[i] = 0;
            ticks[i]   = 0;
        end
        rst0 = 1'b0;
        rst1 = 1'b0;
        rst2 = 1'b0;

        repeat (4) cycle(1'b0, 1'b0, 1'b0);
        chk("reset_ena_all", longint'(ena_v), 0);

        repeat (10_000) cycle(1'b1, 1'b1, 1'b1);
        chk("first_tick0", first_n[0], 11);
        chk("first_tick1", first_n[1], 10);
        chk("first_tick2", first_n[2], 1);
        chk("ticks0_10000", ticks[0], 912);
        chk("ticks1_10000", ticks[1], 1000);
        chk("ticks2_10000", ticks[2], 10_000);

        // Reset u0 five cycles after one of its ticks, then time the restart.
        found = 1'b0;
        for (int j = 0; j < 20; j++) begin
            cycle(1'b1, 1'b1, 1'b1);
            if (ena_v[0] === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        chk("tick0_seen_before_reset", longint'(found), 1);
        repeat (5) cycle(1'b1, 1'b1, 1'b1);
        repeat (3) begin
            cycle(1'b0, 1'b1, 1'b1);
            chk("ena0_during_reset", longint'(ena_v[0]), 0);
        end
        k = 0;
        for (int j = 1; j <= 20; j++) begin
            cycle(1'b1, 1'b1, 1'b1);
            if (ena_v[0] === 1'b1) begin
                k = j;
                break;
            end
        end
        chk("restart_k0", longint'(k), 11);

        cycle(1'b1, 1'b1, 1'b0);
        chk("ena2_drop_on_reset", longint'(ena_v[2]), 0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("ena2_back_high", longint'(ena_v[2]), 1);

        repeat (40) begin
            r0  = ($urandom_range(0, 3) != 0);
            r1  = ($urandom_range(0, 3) != 0);
            r2  = ($urandom_range(0, 3) != 0);
            len = $urandom_range(1, 40);
            repeat (len) cycle(r0, r1, r2);
        end
        repeat (250) cycle(1'b1, 1'b1, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
